// File: rtl/aes_mix_word.sv
// AES MixColumns / InvMixColumns on one 32-bit column, built from chained xtime.
// Provides a combinational result and an optional registered, valid-qualified copy.
module aes_mix_word #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] w_i,
  input  logic        inv_i,
  input  logic        valid_i,
  output logic [31:0] mixw_o,
  output logic [31:0] mixw_q_o,
  output logic        valid_o
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a;
  logic [3:0][7:0] m2;
  logic [3:0][7:0] m4;
  logic [3:0][7:0] m8;
  logic [3:0][7:0] b;

  always_comb begin
    a = w_i;
    for (int k = 0; k < 4; k++) begin
      m2[k] = xtime(a[k]);
      m4[k] = xtime(m2[k]);
      m8[k] = xtime(m4[k]);
    end
    b = '0;
    // Row i uses byte i as the diagonal; the other coefficients rotate with it.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] i0, i1, i2, i3;
      i0 = 2'(i);
      i1 = 2'(i + 1);
      i2 = 2'(i + 2);
      i3 = 2'(i + 3);
      if (!inv_i) begin
        b[i0] = m2[i0] ^ (m2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
      end else begin
        b[i0] = (m8[i0] ^ m4[i0] ^ m2[i0]) ^
                (m8[i1] ^ m2[i1] ^ a[i1]) ^
                (m8[i2] ^ m4[i2] ^ a[i2]) ^
                (m8[i3] ^ a[i3]);
      end
    end
  end

  assign mixw_o = b;

  if (REG_OUT) begin : g_reg
    logic [31:0] mix_q;
    logic        valid_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        mix_q   <= 32'h0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_i;
        if (valid_i) begin
          mix_q <= mixw_o;
        end
      end
    end

    assign mixw_q_o = mix_q;
    assign valid_o  = valid_q;
  end else begin : g_noreg
    assign mixw_q_o = 32'h0;
    assign valid_o  = 1'b0;
  end

endmodule

// File: tb/tb_aes_mix_word.sv
// Self-checking bench for aes_mix_word: known vectors, round trips and a
// scoreboard on the registered path.
module tb_aes_mix_word;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] w;
  logic        inv;
  logic        valid;
  logic [31:0] mixw;
  logic [31:0] mixw_q;
  logic        valid_q;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  aes_mix_word #(.REG_OUT(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .w_i     (w),
    .inv_i   (inv),
    .valid_i (valid),
    .mixw_o  (mixw),
    .mixw_q_o(mixw_q),
    .valid_o (valid_q)
  );

  // Generic shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = s[7] ? ((s << 1) ^ 8'h1b) : (s << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_mix(input logic [31:0] x, input logic inverse);
    logic [7:0]  c[4];
    logic [31:0] r;
    if (inverse) c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         c = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 32'h0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[8*i +: 8] = r[8*i +: 8] ^ gmul(x[8*j +: 8], c[(j - i + 4) % 4]);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    inv   = 1'b0;
    w     = 32'h1a96de77;
    @(posedge clk); #1;
    total++;
    if (mixw_q !== 32'h0 || valid_q !== 1'b0) begin
      $display("FAIL reset_state: got q=%h v=%b, want q=00000000 v=0", mixw_q, valid_q);
    end else passed++;
    total++;
    if (mixw !== 32'he5b06b1b) begin
      $display("FAIL reset_comb: got %h, want e5b06b1b", mixw);
    end else passed++;
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_forward_comb();
    logic [31:0] ins[6];
    logic [31:0] outs[6];
    ins  = '{32'h1a96de77, 32'he598271e, 32'h3b87db49, 32'h305dbfd4,
             32'h455313db, 32'h01010101};
    outs = '{32'he5b06b1b, 32'h4c260628, 32'hf1ca4d58, 32'he5816604,
             32'hbca14d8e, 32'h01010101};
    inv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w = ins[k];
      #1;
      total++;
      if (mixw !== outs[k]) begin
        $display("FAIL fwd_comb[%0d]: in %h got %h, want %h", k, ins[k], mixw, outs[k]);
      end else passed++;
    end
  endtask

  task automatic test_inverse_comb();
    logic [31:0] r;
    logic [31:0] f;
    inv = 1'b1;
    w   = 32'he5b06b1b;
    #1;
    total++;
    if (mixw !== 32'h1a96de77) begin
      $display("FAIL inv_comb0: got %h, want 1a96de77", mixw);
    end else passed++;
    w = 32'hbca14d8e;
    #1;
    total++;
    if (mixw !== 32'h455313db) begin
      $display("FAIL inv_comb1: got %h, want 455313db", mixw);
    end else passed++;
    for (int k = 0; k < 16; k++) begin
      r   = $urandom;
      inv = 1'b0;
      w   = r;
      #1;
      f = mixw;
      total++;
      if (f !== model_mix(r, 1'b0)) begin
        $display("FAIL rt_fwd[%0d]: in %h got %h, want %h", k, r, f, model_mix(r, 1'b0));
      end else passed++;
      inv = 1'b1;
      w   = f;
      #1;
      total++;
      if (mixw !== r) begin
        $display("FAIL rt_inv[%0d]: in %h got %h, want %h", k, f, mixw, r);
      end else passed++;
    end
    inv = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[4];
    logic [31:0] outs[4];
    logic [31:0] exp;
    ins  = '{32'h1a96de77, 32'he598271e, 32'h3b87db49, 32'h305dbfd4};
    outs = '{32'he5b06b1b, 32'h4c260628, 32'hf1ca4d58, 32'he5816604};
    inv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w     = ins[k];
      valid = 1'b1;
      sb.push_back(outs[k]);
      @(posedge clk); #1;
      total++;
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
      if (valid_q !== 1'b1 || mixw_q !== exp) begin
        $display("FAIL b2b[%0d]: got q=%h v=%b, want q=%h v=1", k, mixw_q, valid_q, exp);
      end else passed++;
    end
    valid = 1'b0;
  endtask

  task automatic test_gap();
    valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      @(posedge clk); #1;
      total++;
      if (valid_q !== 1'b0 || mixw_q !== 32'he5816604) begin
        $display("FAIL gap[%0d]: got q=%h v=%b, want q=e5816604 v=0", k, mixw_q, valid_q);
      end else passed++;
    end
  endtask

  task automatic test_inv_switch();
    logic [31:0] exp;
    logic [31:0] r;
    for (int k = 0; k < 6; k++) begin
      r     = $urandom;
      w     = r;
      inv   = k[0];
      valid = 1'b1;
      sb.push_back(model_mix(r, k[0]));
      @(posedge clk); #1;
      total++;
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
      if (valid_q !== 1'b1 || mixw_q !== exp) begin
        $display("FAIL inv_switch[%0d]: got q=%h v=%b, want q=%h v=1", k, mixw_q, valid_q, exp);
      end else passed++;
    end
    inv = 1'b0;
  endtask

  task automatic test_reset_midstream();
    valid = 1'b1;
    inv   = 1'b0;
    w     = 32'h455313db;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (mixw_q !== 32'h0 || valid_q !== 1'b0) begin
      $display("FAIL reset_mid: got q=%h v=%b, want q=00000000 v=0", mixw_q, valid_q);
    end else passed++;
    total++;
    if (mixw !== 32'hbca14d8e) begin
      $display("FAIL reset_mid_comb0: got %h, want bca14d8e", mixw);
    end else passed++;
    w = 32'h01010101;
    #1;
    total++;
    if (mixw !== 32'h01010101) begin
      $display("FAIL reset_mid_comb1: got %h, want 01010101", mixw);
    end else passed++;
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    inv   = 1'b0;
    w     = 32'h0;
    test_reset();
    test_forward_comb();
    test_inverse_comb();
    test_back_to_back();
    test_gap();
    test_inv_switch();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
